// File: rtl/irtransmitter_wb8_pkg.sv
// Shared definitions for the NEC infrared transmitter: register offsets,
// control/status bit positions, NEC durations in 562.5 us units and the
// transmitter state encoding.
package irtransmitter_wb8_pkg;

    // Register offsets on the 2-bit wishbone address
    localparam logic [1:0] REG_ADDR = 2'd0;
    localparam logic [1:0] REG_CMD  = 2'd1;
    localparam logic [1:0] REG_CTRL = 2'd2;

    // Control bits (write to REG_CTRL)
    localparam int CTRL_START   = 0;
    localparam int CTRL_REPEAT  = 1;
    localparam int CTRL_CLRDONE = 2;
    localparam int CTRL_IRQEN   = 3;

    // NEC durations, counted in units
    localparam logic [4:0] LEAD_MARK_UNITS    = 5'd16;
    localparam logic [4:0] LEAD_SPACE_UNITS   = 5'd8;
    localparam logic [4:0] REPEAT_SPACE_UNITS = 5'd4;
    localparam logic [4:0] BIT_UNITS          = 5'd1;
    localparam logic [4:0] ONE_SPACE_UNITS    = 5'd3;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LEAD_MARK  = 3'd1,
        ST_LEAD_SPACE = 3'd2,
        ST_BIT_MARK   = 3'd3,
        ST_BIT_SPACE  = 3'd4,
        ST_STOP_MARK  = 3'd5
    } irtx_state_e;

    // True for states in which the IR envelope is on
    function automatic logic irtx_is_mark(input irtx_state_e s);
        return (s == ST_LEAD_MARK) || (s == ST_BIT_MARK) || (s == ST_STOP_MARK);
    endfunction

endpackage

// File: rtl/irtransmitter_wb8_if.sv
// Wishbone-8 responder bus bundle for the IR transmitter.
interface irtransmitter_wb8_if;
    logic [1:0] I_wb_adr;
    logic [7:0] I_wb_dat;
    logic       I_wb_stb;
    logic       I_wb_we;
    logic [7:0] O_wb_dat;
    logic       O_wb_ack;

    modport slave (
        input  I_wb_adr, I_wb_dat, I_wb_stb, I_wb_we,
        output O_wb_dat, O_wb_ack
    );

    modport master (
        output I_wb_adr, I_wb_dat, I_wb_stb, I_wb_we,
        input  O_wb_dat, O_wb_ack
    );
endinterface

// File: rtl/irtransmitter_wb8_carrier.sv
// Carrier generator: free-running phase counter that restarts at the first
// cycle of every mark so each burst begins with the high part of the carrier.
// The LED output is registered and already gated by the envelope.
module irtx_carrier #(
    parameter int CARRIER_CYCLES = 661
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_restart,
    input  logic i_envelope_next,
    output logic o_led
);
    localparam int PHASE_W = $clog2(CARRIER_CYCLES + 1);
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(CARRIER_CYCLES - 1);
    localparam logic [PHASE_W-1:0] PHASE_HIGH = PHASE_W'(CARRIER_CYCLES / 3);

    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W-1:0] w_phase_next;

    // Next carrier phase: restart on mark entry, otherwise wrap around the period
    always_comb begin
        w_phase_next = r_phase;
        if (i_restart) begin
            w_phase_next = '0;
        end else if (r_phase == PHASE_LAST) begin
            w_phase_next = '0;
        end else begin
            w_phase_next = r_phase + PHASE_W'(1);
        end
    end

    // Phase register and modulated LED output
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase <= '0;
            o_led   <= 1'b0;
        end else begin
            r_phase <= w_phase_next;
            o_led   <= i_envelope_next & (w_phase_next < PHASE_HIGH);
        end
    end
endmodule

// File: rtl/irtransmitter_wb8.sv
// NEC infrared transmitter with a Wishbone-8 register interface.
// Optional macro IRTX_IRQ_EN adds the O_interrupt output (done & irqen).
module irtransmitter_wb8
    import irtransmitter_wb8_pkg::*;
#(
    parameter int CLOCKFREQ   = 25125000,
    parameter int CARRIERFREQ = 38000
) (
    input  logic               I_wb_clk,
    input  logic               I_reset_n,
    irtransmitter_wb8_if.slave wb,
    output logic               O_ir_led,
    output logic               O_ir_envelope
`ifdef IRTX_IRQ_EN
    ,
    output logic               O_interrupt
`endif
);
    localparam int UNIT_CYCLES    = (CLOCKFREQ / 16000) * 9;
    localparam int CARRIER_CYCLES = CLOCKFREQ / CARRIERFREQ;
    localparam int UNIT_W         = $clog2(UNIT_CYCLES + 1);
    localparam logic [UNIT_W-1:0] UNIT_LAST = UNIT_W'(UNIT_CYCLES - 1);

    irtx_state_e       r_state, w_state_next;
    logic [UNIT_W-1:0] r_unit_cnt, w_unit_cnt_next;
    logic [4:0]        r_dur_cnt, w_dur_cnt_next;
    logic [4:0]        r_bit_cnt, w_bit_cnt_next;
    logic [31:0]       r_shift, w_shift_next;
    logic              r_repeat, w_repeat_next;
    logic [7:0]        r_addr, r_cmd, r_dat;
    logic              r_done, r_irqen, r_ack, r_envelope;
    logic [4:0]        w_units;
    logic              w_last, w_done_set, w_busy;
    logic              w_wr, w_wr_ctrl, w_go, w_restart;

    assign w_busy    = (r_state != ST_IDLE);
    assign w_wr      = wb.I_wb_stb & wb.I_wb_we;
    assign w_wr_ctrl = w_wr & (wb.I_wb_adr == REG_CTRL);
    // START or REPEAT only launch a transmission from idle
    assign w_go      = w_wr_ctrl & ~w_busy
                     & (wb.I_wb_dat[CTRL_START] | wb.I_wb_dat[CTRL_REPEAT]);
    assign w_restart = irtx_is_mark(w_state_next) & (w_state_next != r_state);

    // Length of the current state in units and end-of-state detection
    always_comb begin
        w_units = BIT_UNITS;
        case (r_state)
            ST_LEAD_MARK:  w_units = LEAD_MARK_UNITS;
            ST_LEAD_SPACE: w_units = r_repeat ? REPEAT_SPACE_UNITS : LEAD_SPACE_UNITS;
            ST_BIT_SPACE:  w_units = r_shift[0] ? ONE_SPACE_UNITS : BIT_UNITS;
            default:       w_units = BIT_UNITS;
        endcase
        w_last = w_busy && (r_unit_cnt == UNIT_LAST) && (r_dur_cnt == w_units - 5'd1);
    end

    // Next-state logic: unit/duration counting, bit shifting and transitions
    always_comb begin
        w_state_next    = r_state;
        w_unit_cnt_next = r_unit_cnt;
        w_dur_cnt_next  = r_dur_cnt;
        w_bit_cnt_next  = r_bit_cnt;
        w_shift_next    = r_shift;
        w_repeat_next   = r_repeat;
        w_done_set      = 1'b0;
        if (w_busy) begin
            if (r_unit_cnt == UNIT_LAST) begin
                w_unit_cnt_next = '0;
                w_dur_cnt_next  = w_last ? 5'd0 : r_dur_cnt + 5'd1;
            end else begin
                w_unit_cnt_next = r_unit_cnt + UNIT_W'(1);
            end
        end else begin
            w_unit_cnt_next = '0;
        end
        case (r_state)
            ST_IDLE: begin
                if (w_go) begin
                    w_state_next    = ST_LEAD_MARK;
                    w_unit_cnt_next = '0;
                    w_dur_cnt_next  = 5'd0;
                    w_bit_cnt_next  = 5'd0;
                    w_shift_next    = {~r_cmd, r_cmd, ~r_addr, r_addr};
                    w_repeat_next   = wb.I_wb_dat[CTRL_REPEAT];
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_LEAD_MARK: begin
                if (w_last) w_state_next = ST_LEAD_SPACE;
                else        w_state_next = ST_LEAD_MARK;
            end
            ST_LEAD_SPACE: begin
                if (w_last) w_state_next = r_repeat ? ST_STOP_MARK : ST_BIT_MARK;
                else        w_state_next = ST_LEAD_SPACE;
            end
            ST_BIT_MARK: begin
                if (w_last) w_state_next = ST_BIT_SPACE;
                else        w_state_next = ST_BIT_MARK;
            end
            ST_BIT_SPACE: begin
                if (w_last) begin
                    w_shift_next   = {1'b0, r_shift[31:1]};
                    w_bit_cnt_next = r_bit_cnt + 5'd1;
                    w_state_next   = (r_bit_cnt == 5'd31) ? ST_STOP_MARK : ST_BIT_MARK;
                end else begin
                    w_state_next = ST_BIT_SPACE;
                end
            end
            ST_STOP_MARK: begin
                if (w_last) begin
                    w_state_next = ST_IDLE;
                    w_done_set   = 1'b1;
                end else begin
                    w_state_next = ST_STOP_MARK;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Transmitter state, counters, shift register and envelope output
    always_ff @(posedge I_wb_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            r_state    <= ST_IDLE;
            r_unit_cnt <= '0;
            r_dur_cnt  <= 5'd0;
            r_bit_cnt  <= 5'd0;
            r_shift    <= 32'd0;
            r_repeat   <= 1'b0;
            r_envelope <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_unit_cnt <= w_unit_cnt_next;
            r_dur_cnt  <= w_dur_cnt_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_shift    <= w_shift_next;
            r_repeat   <= w_repeat_next;
            r_envelope <= irtx_is_mark(w_state_next);
        end
    end

    // Register file, sticky done flag and registered bus response
    always_ff @(posedge I_wb_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            r_addr  <= 8'd0;
            r_cmd   <= 8'd0;
            r_done  <= 1'b0;
            r_irqen <= 1'b0;
            r_ack   <= 1'b0;
            r_dat   <= 8'd0;
        end else begin
            r_ack <= wb.I_wb_stb;
            if (w_wr && !w_busy && wb.I_wb_adr == REG_ADDR) r_addr <= wb.I_wb_dat;
            if (w_wr && !w_busy && wb.I_wb_adr == REG_CMD)  r_cmd  <= wb.I_wb_dat;
            if (w_wr_ctrl) r_irqen <= wb.I_wb_dat[CTRL_IRQEN];
            // Completion has priority over a simultaneous CLRDONE
            if (w_done_set)                                r_done <= 1'b1;
            else if (w_go)                                 r_done <= 1'b0;
            else if (w_wr_ctrl && wb.I_wb_dat[CTRL_CLRDONE]) r_done <= 1'b0;
            if (wb.I_wb_stb) begin
                case (wb.I_wb_adr)
                    REG_ADDR: r_dat <= r_addr;
                    REG_CMD:  r_dat <= r_cmd;
                    REG_CTRL: r_dat <= {4'b0000, r_irqen, 1'b0, r_done, w_busy};
                    default:  r_dat <= 8'd0;
                endcase
            end
        end
    end

`ifdef IRTX_IRQ_EN
    logic r_irq;
    // Level interrupt following the next-cycle done and irqen values
    always_ff @(posedge I_wb_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            r_irq <= 1'b0;
        end else if (w_done_set) begin
            r_irq <= w_wr_ctrl ? wb.I_wb_dat[CTRL_IRQEN] : r_irqen;
        end else if (w_go || (w_wr_ctrl && wb.I_wb_dat[CTRL_CLRDONE])) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_done & (w_wr_ctrl ? wb.I_wb_dat[CTRL_IRQEN] : r_irqen);
        end
    end
    assign O_interrupt = r_irq;
`endif

    irtx_carrier #(
        .CARRIER_CYCLES (CARRIER_CYCLES)
    ) u_carrier (
        .i_clk           (I_wb_clk),
        .i_rst_n         (I_reset_n),
        .i_restart       (w_restart),
        .i_envelope_next (irtx_is_mark(w_state_next)),
        .o_led           (O_ir_led)
    );

    assign O_ir_envelope = r_envelope;
    assign wb.O_wb_ack   = r_ack;
    assign wb.O_wb_dat   = r_dat;
endmodule
